// File: rtl/avalon_cmd_master_if.sv
// Signal bundle between avalon_cmd_master and its environment: the local
// command port, the local response port and the Avalon-MM master port.
interface avalon_cmd_master_if;
  // local command port
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  // local response port
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_write;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  // Avalon-MM side
  logic [7:0] address;
  logic       Write;
  logic       read;
  logic [7:0] writedata;
  logic       waitrequest;
  logic [7:0] readdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, waitrequest, readdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, address, Write, read, writedata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, waitrequest, readdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_error, address, Write, read, writedata
  );
endinterface

// File: rtl/avalon_cmd_master.sv
// Avalon-MM command master: buffers local read/write commands in a small FIFO,
// issues them one at a time as single-cycle strobes, waits for waitrequest to
// drop (or times out) and hands the result back on a valid/ready port.
module avalon_cmd_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input logic                 clk,
  input logic                 reset,
  avalon_cmd_master_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;

  // FIFO entries are {write, addr, wdata}; pointers carry an extra wrap bit
  logic [16:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW:0]   wptr_r;
  logic [AW:0]   rptr_r;
  logic [16:0]   head_s;
  logic          empty_s;
  logic          full_s;
  logic          push_s;
  logic          pop_s;
  logic          done_ok_s;
  logic          done_to_s;
  logic          rsp_take_s;

  logic          tx_write_r;
  logic [7:0]    address_r;
  logic [7:0]    writedata_r;
  logic          read_r;
  logic          write_r;
  logic [CW-1:0] cnt_r;
  logic          rsp_valid_r;
  logic          rsp_write_r;
  logic [7:0]    rsp_rdata_r;
  logic          rsp_error_r;

  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign head_s  = fifo_mem_r[rptr_r[AW-1:0]];
  assign push_s  = bus.cmd_valid & ~full_s;

  // cmd_ready depends only on the pointer registers
  assign bus.cmd_ready = ~full_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_write = rsp_write_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_error = rsp_error_r;
  assign bus.address   = address_r;
  assign bus.writedata = writedata_r;
  assign bus.read      = read_r;
  assign bus.Write     = write_r;

  // FIFO storage write; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wptr_r[AW-1:0]] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
    end
  end

  // FIFO pointers; reset flushes the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and control decode; a pop always leads into STROBE
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    done_ok_s   = 1'b0;
    done_to_s   = 1'b0;
    rsp_take_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_STROBE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STROBE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        // waitrequest low takes priority over an expiring counter
        if (!bus.waitrequest) begin
          done_ok_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          done_to_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_take_s = 1'b1;
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = ST_STROBE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Transaction registers and strobes; strobes are high only in STROBE
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_write_r  <= 1'b0;
      address_r   <= 8'h00;
      writedata_r <= 8'h00;
      read_r      <= 1'b0;
      write_r     <= 1'b0;
    end else begin
      read_r  <= pop_s & ~head_s[16];
      write_r <= pop_s & head_s[16];
      if (pop_s) begin
        tx_write_r  <= head_s[16];
        address_r   <= head_s[15:8];
        writedata_r <= head_s[7:0];
      end
    end
  end

  // Wait counter: cleared in STROBE, counts WAIT cycles, saturates at the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= CNT_ZERO;
    end else if (state_r == ST_STROBE) begin
      cnt_r <= CNT_ZERO;
    end else if ((state_r == ST_WAIT) && (cnt_r != CNT_LAST)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Response registers, held stable until the consumer takes them
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= 8'h00;
      rsp_error_r <= 1'b0;
    end else if (done_ok_s) begin
      rsp_valid_r <= 1'b1;
      rsp_write_r <= tx_write_r;
      rsp_rdata_r <= tx_write_r ? 8'h00 : bus.readdata;
      rsp_error_r <= 1'b0;
    end else if (done_to_s) begin
      rsp_valid_r <= 1'b1;
      rsp_write_r <= tx_write_r;
      rsp_rdata_r <= 8'h00;
      rsp_error_r <= 1'b1;
    end else if (rsp_take_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_cmd_master.sv
// Directed testbench for avalon_cmd_master: a behavioural Avalon slave with
// programmable latency, plus scoreboards for strobes and responses.
module tb_avalon_cmd_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_cmd_master_if bus();

  avalon_cmd_master #(.FIFO_DEPTH(4), .TIMEOUT(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  ref_mem [256];
  logic [7:0]  sl_mem  [256];
  logic [9:0]  exp_rsp [$];   // {write, error, rdata}
  logic [16:0] exp_stb [$];   // {write, addr, wdata}
  int wait_lat = 1;
  bit stall = 1'b0;
  int sl_cnt = 0;
  bit prev_stb = 1'b0;
  bit mon_stb;
  logic [16:0] mon_e;
  logic [9:0]  mon_r;
  int last_stb_cyc = 0;
  int hs_cyc = -10;
  bit b2b_mode = 1'b0;
  int b2b_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cycle counter
  always @(posedge clk) cyc++;

  // Behavioural slave: waitrequest drops wait_lat cycles after the strobe
  always @(negedge clk) begin
    if (bus.read === 1'b1 || bus.Write === 1'b1) begin
      if (bus.Write === 1'b1) sl_mem[bus.address] = bus.writedata;
      sl_cnt = wait_lat;
      bus.waitrequest = 1'b1;
      bus.readdata = 8'hEE;
    end else if (sl_cnt > 0) begin
      sl_cnt--;
      if (sl_cnt == 0 && !stall) begin
        bus.waitrequest = 1'b0;
        bus.readdata = sl_mem[bus.address];
      end else begin
        bus.waitrequest = 1'b1;
        bus.readdata = 8'hEE;
      end
    end else begin
      bus.waitrequest = 1'b1;
      bus.readdata = 8'hEE;
    end
  end

  // Monitor: strobe and response scoreboards
  always @(negedge clk) begin
    mon_stb = (bus.read === 1'b1) || (bus.Write === 1'b1);
    if (mon_stb) begin
      check("strobe_width", 32'(prev_stb), 32'd0);
      if (exp_stb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        mon_e = exp_stb.pop_front();
        check("stb_kind", 32'({bus.Write, bus.read}), 32'({mon_e[16], ~mon_e[16]}));
        check("stb_addr", 32'(bus.address), 32'(mon_e[15:8]));
        if (mon_e[16]) check("stb_wdata", 32'(bus.writedata), 32'(mon_e[7:0]));
      end
      if (b2b_mode) begin
        if (b2b_seen > 0) check("b2b_gap", 32'(cyc), 32'(hs_cyc + 1));
        b2b_seen++;
      end
      last_stb_cyc = cyc;
    end
    prev_stb = mon_stb;
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      hs_cyc = cyc;
      if (exp_rsp.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        mon_r = exp_rsp.pop_front();
        check("rsp", 32'({bus.rsp_write, bus.rsp_error, bus.rsp_rdata}), 32'(mon_r));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic err);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("push_ready", 32'(bus.cmd_ready), 32'd1);
    exp_stb.push_back({wr, addr, wdata});
    exp_rsp.push_back({wr, err, (wr || err) ? 8'h00 : ref_mem[addr]});
    if (wr) ref_mem[addr] = wdata;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_rsp.size()), 32'd0);
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.rsp_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i) ^ 8'h5C;
      sl_mem[i]  = 8'(i) ^ 8'h5C;
    end
    bus.cmd_valid   = 1'b0;
    bus.cmd_write   = 1'b0;
    bus.cmd_addr    = 8'h00;
    bus.cmd_wdata   = 8'h00;
    bus.rsp_ready   = 1'b0;
    bus.waitrequest = 1'b1;
    bus.readdata    = 8'hEE;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_strobes", 32'({bus.read, bus.Write}), 32'd0);
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_writedata", 32'(bus.writedata), 32'd0);
    check("rst_rsp_fields", 32'({bus.rsp_write, bus.rsp_error, bus.rsp_rdata}), 32'd0);

    // 1: write, slave drops waitrequest 4 cycles after strobe
    wait_lat = 4;
    bus.rsp_ready = 1'b1;
    push_cmd(1'b1, 8'h03, 8'hA5, 1'b0);
    check("t1_no_early_strobe", 32'(bus.Write), 32'd0);
    tick();
    check("t1_strobe_latency", 32'(bus.Write), 32'd1);
    repeat (4) tick();
    check("t1_rsp_not_yet", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t1_rsp_latency", 32'(bus.rsp_valid), 32'd1);
    wait_drain();

    // 2: read back
    push_cmd(1'b0, 8'h03, 8'h00, 1'b0);
    wait_drain();

    // 3: fill the FIFO behind a stalled response
    wait_lat = 1;
    bus.rsp_ready = 1'b0;
    push_cmd(1'b1, 8'h11, 8'h01, 1'b0);
    wait_rsp_valid("t3_first_rsp");
    push_cmd(1'b0, 8'h11, 8'h00, 1'b0);
    push_cmd(1'b1, 8'h12, 8'h02, 1'b0);
    push_cmd(1'b0, 8'h12, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h03, 8'h00, 1'b0);
    check("t3_full", 32'(bus.cmd_ready), 32'd0);
    check("t3_rsp_held", 32'({bus.rsp_valid, bus.rsp_write}), 32'd3);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h11;
    bus.cmd_wdata = 8'h00;
    repeat (3) tick();
    check("t3_still_full", 32'(bus.cmd_ready), 32'd0);
    bus.rsp_ready = 1'b1;
    push_cmd(1'b0, 8'h11, 8'h00, 1'b0);
    wait_drain();

    // 4: timeout, then the queued command completes normally
    wait_lat = 1;
    stall = 1'b1;
    push_cmd(1'b0, 8'h30, 8'h00, 1'b1);
    repeat (3) tick();
    push_cmd(1'b1, 8'h20, 8'h5A, 1'b0);
    stall = 1'b0;
    wait_rsp_valid("t4_rsp");
    check("t4_timeout_cycles", 32'(cyc - last_stb_cyc), 32'd33);
    check("t4_err_fields", 32'({bus.rsp_error, bus.rsp_rdata}), 32'h100);
    wait_drain();

    // 5: reset during WAIT with two commands queued
    stall = 1'b1;
    push_cmd(1'b0, 8'h03, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h12, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h11, 8'h00, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rsp.delete();
    exp_stb.delete();
    check("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("t5_strobes", 32'({bus.read, bus.Write}), 32'd0);
    check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (10) tick();
    check("t5_quiet_rsp", 32'(bus.rsp_valid), 32'd0);
    check("t5_quiet_strobes", 32'({bus.read, bus.Write}), 32'd0);
    stall = 1'b0;

    // 6: back-to-back reads
    wait_lat = 1;
    b2b_mode = 1'b1;
    b2b_seen = 0;
    push_cmd(1'b0, 8'h03, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h20, 8'h00, 1'b0);
    push_cmd(1'b0, 8'h11, 8'h00, 1'b0);
    wait_drain();
    b2b_mode = 1'b0;
    check("t6_strobe_count", 32'(b2b_seen), 32'd3);

    repeat (3) tick();
    check("final_stb_empty", 32'(exp_stb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
